// File: rtl/array_divider_pkg.sv
// Shared helpers for the pipelined restoring array divider: register
// placement along the row chain and elaboration-time parameter checks.
package array_divider_pkg;

  localparam int MAX_DATAWIDTH = 32;

  // Row index (1..n) after which pipeline register k (1..s) sits.
  function automatic int stage_after_row(int k, int n, int s);
    return (k * n) / (s + 1);
  endfunction

  function automatic bit is_boundary(int row, int n, int s);
    for (int k = 1; k <= s; k++) begin
      if (stage_after_row(k, n, s) == row) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic bit params_ok(int n, int s, int id);
    return (n >= 1) && (n <= MAX_DATAWIDTH) && (s >= 0) && (s <= n - 1) && (id >= 0);
  endfunction

endpackage

// File: rtl/divider_row.sv
// One combinational restoring-division row: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference only when it did not borrow.
module divider_row #(
  parameter int N = 4
) (
  input  logic [N-1:0] rem_in,
  input  logic         dividend_bit,
  input  logic [N-1:0] B,
  output logic [N-1:0] rem_out,
  output logic         q_bit
);

  logic [N:0] shifted;
  logic [N:0] trial;
  logic       borrow;

  // With rem_in < B the difference lies in [-B, B-1], so the N+1-bit
  // result is exact and its top bit is the borrow.
  assign shifted = {rem_in, dividend_bit};
  assign trial   = shifted - {1'b0, B};
  assign borrow  = trial[N];
  assign q_bit   = ~borrow;
  assign rem_out = borrow ? shifted[N-1:0] : trial[N-1:0];

endmodule

// File: rtl/array_divider.sv
// Pipelined restoring array divider: 2N-bit dividend / N-bit divisor with
// NUM_PIPELINE_STAGES internal row registers plus one output register.
module array_divider
  import array_divider_pkg::*;
#(
  parameter int DATAWIDTH           = 4,
  parameter int NUM_PIPELINE_STAGES = 1,
  parameter int INSTANCE_ID         = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_valid,
  input  logic [2*DATAWIDTH-1:0]   Z,
  input  logic [DATAWIDTH-1:0]     B,
  output logic                     o_valid,
  output logic [DATAWIDTH-1:0]     Q,
  output logic [DATAWIDTH-1:0]     R,
  output logic                     o_div_zero,
  output logic                     o_overflow
);

  localparam int N = DATAWIDTH;
  localparam int S = NUM_PIPELINE_STAGES;

  if (!params_ok(N, S, INSTANCE_ID)) begin : g_bad_params
    $error("array_divider: DATAWIDTH must be 1..32 and NUM_PIPELINE_STAGES 0..DATAWIDTH-1");
  end

  // Node i carries the state leaving row i (registered or not); node 0 is the input.
  logic [N-1:0] rem_n [0:N];
  logic [N-1:0] quo_n [0:N];
  logic [N-1:0] zlo_n [0:N-1];
  logic [N-1:0] div_n [0:N-1];
  logic         dz_n  [0:N];
  logic         ovf_n [0:N];
  logic         vld_n [0:N];

  assign rem_n[0] = Z[2*N-1:N];
  assign quo_n[0] = '0;
  assign zlo_n[0] = Z[N-1:0];
  assign div_n[0] = B;
  assign dz_n[0]  = (B == '0);
  assign ovf_n[0] = (B != '0) && (Z[2*N-1:N] >= B);
  assign vld_n[0] = i_valid;

  for (genvar i = 1; i <= N; i++) begin : g_row
    logic [N-1:0] rem_d;
    logic [N-1:0] quo_d;
    logic         q_bit;

    // Low dividend half is shifted left each row so the next bit is always the MSB.
    divider_row #(.N(N)) u_row (
      .rem_in       (rem_n[i-1]),
      .dividend_bit (zlo_n[i-1][N-1]),
      .B            (div_n[i-1]),
      .rem_out      (rem_d),
      .q_bit        (q_bit)
    );

    assign quo_d = (quo_n[i-1] << 1) | N'(q_bit);

    if (is_boundary(i, N, S)) begin : g_reg
      logic [N-1:0] rem_q, quo_q, zlo_q, div_q;
      logic         dz_q, ovf_q, vld_q;

      // NOTE: sequential state uses non-blocking assignments so every register
      // samples its pre-edge inputs regardless of process evaluation order.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rem_q <= '0;
          quo_q <= '0;
          zlo_q <= '0;
          div_q <= '0;
          dz_q  <= 1'b0;
          ovf_q <= 1'b0;
          vld_q <= 1'b0;
        end else begin
          vld_q <= vld_n[i-1];
          if (vld_n[i-1]) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            zlo_q <= zlo_n[i-1] << 1;
            div_q <= div_n[i-1];
            dz_q  <= dz_n[i-1];
            ovf_q <= ovf_n[i-1];
          end
        end
      end

      assign rem_n[i] = rem_q;
      assign quo_n[i] = quo_q;
      assign zlo_n[i] = zlo_q;
      assign div_n[i] = div_q;
      assign dz_n[i]  = dz_q;
      assign ovf_n[i] = ovf_q;
      assign vld_n[i] = vld_q;
    end else begin : g_comb
      assign rem_n[i] = rem_d;
      assign quo_n[i] = quo_d;
      assign dz_n[i]  = dz_n[i-1];
      assign ovf_n[i] = ovf_n[i-1];
      assign vld_n[i] = vld_n[i-1];
      if (i < N) begin : g_fwd
        assign zlo_n[i] = zlo_n[i-1] << 1;
        assign div_n[i] = div_n[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid    <= 1'b0;
      Q          <= '0;
      R          <= '0;
      o_div_zero <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      o_valid <= vld_n[N];
      if (vld_n[N]) begin
        if (dz_n[N] || ovf_n[N]) begin
          Q <= '1;
          R <= '0;
        end else begin
          Q <= quo_n[N];
          R <= rem_n[N];
        end
        o_div_zero <= dz_n[N];
        o_overflow <= ovf_n[N];
      end
    end
  end

endmodule

// File: tb/tb_array_divider.sv
// Self-checking bench: every pipeline depth for N=4 and N=8 runs in parallel
// on shared stimulus and is compared against a plain-arithmetic divide model.
module tb_array_divider;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    logic       ov;
  } res_t;

  typedef struct {
    bit    wide;
    int    z;
    int    b;
    res_t  e;
    string name;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        v4 = 1'b0;
  logic [7:0]  z4 = '0;
  logic [3:0]  b4 = '0;
  logic        vo4 [4];
  logic [3:0]  q4  [4];
  logic [3:0]  r4  [4];
  logic        dz4 [4];
  logic        of4 [4];

  logic        v8 = 1'b0;
  logic [15:0] z8 = '0;
  logic [7:0]  b8 = '0;
  logic        vo8 [8];
  logic [7:0]  q8  [8];
  logic [7:0]  r8  [8];
  logic        dz8 [8];
  logic        of8 [8];

  int total = 0;
  int bad   = 0;

  int   s4z[$], s4b[$], s8z[$], s8b[$];
  res_t e4[$], e8[$];

  always #5 clk = ~clk;

  for (genvar s = 0; s < 4; s++) begin : g_n4
    array_divider #(.DATAWIDTH(4), .NUM_PIPELINE_STAGES(s), .INSTANCE_ID(s)) u_dut (
      .clk(clk), .rst(rst), .i_valid(v4), .Z(z4), .B(b4),
      .o_valid(vo4[s]), .Q(q4[s]), .R(r4[s]), .o_div_zero(dz4[s]), .o_overflow(of4[s])
    );
  end

  for (genvar s = 0; s < 8; s++) begin : g_n8
    array_divider #(.DATAWIDTH(8), .NUM_PIPELINE_STAGES(s), .INSTANCE_ID(10 + s)) u_dut (
      .clk(clk), .rst(rst), .i_valid(v8), .Z(z8), .B(b8),
      .o_valid(vo8[s]), .Q(q8[s]), .R(r8[s]), .o_div_zero(dz8[s]), .o_overflow(of8[s])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pk(input int hi, input res_t x);
    return {hi[13:0], x.q, x.r, x.dz, x.ov};
  endfunction

  function automatic res_t mkres(input int q, input int r, input bit dz, input bit ov);
    res_t x;
    x.q = 8'(q); x.r = 8'(r); x.dz = dz; x.ov = ov;
    return x;
  endfunction

  function automatic vec_t mkvec(input bit wide, input int z, input int b, input res_t e, input string name);
    vec_t v;
    v.wide = wide; v.z = z; v.b = b; v.e = e; v.name = name;
    return v;
  endfunction

  // Reference: divide by zero and quotients of 2^n or more are flagged with
  // Q = all ones, R = 0; otherwise ordinary integer division.
  function automatic res_t model(input int n, input int z, input int b);
    int lim = 1 << n;
    if (b == 0) return mkres(lim - 1, 0, 1'b1, 1'b0);
    if (z / b >= lim) return mkres(lim - 1, 0, 1'b0, 1'b1);
    return mkres(z / b, z % b, 1'b0, 1'b0);
  endfunction

  task automatic sample(input bit wide, input int s, output logic v, output res_t x);
    if (wide) begin
      v = vo8[s]; x.q = q8[s]; x.r = r8[s]; x.dz = dz8[s]; x.ov = of8[s];
    end else begin
      v = vo4[s]; x.q = {4'b0, q4[s]}; x.r = {4'b0, r4[s]}; x.dz = dz4[s]; x.ov = of4[s];
    end
  endtask

  task automatic check_all_zero(input string name);
    logic v;
    res_t x;
    for (int s = 0; s < 4; s++) begin
      sample(1'b0, s, v, x);
      check($sformatf("%s_n4s%0d", name, s), pk(int'(v), x), 32'h0);
    end
    for (int s = 0; s < 8; s++) begin
      sample(1'b1, s, v, x);
      check($sformatf("%s_n8s%0d", name, s), pk(int'(v), x), 32'h0);
    end
  endtask

  // One isolated operation: every instance must pulse o_valid exactly once,
  // S+1 cycles after the input, carrying the expected result.
  task automatic op(input bit wide, input int z, input int b, input res_t e, input string name);
    int   ns = wide ? 8 : 4;
    int   lat[8];
    int   pulses[8];
    res_t got[8];
    logic v;
    res_t x;
    for (int s = 0; s < 8; s++) begin
      lat[s] = 0; pulses[s] = 0; got[s] = mkres(0, 0, 1'b0, 1'b0);
    end
    @(negedge clk);
    @(posedge clk);
    #1;
    if (wide) begin z8 = 16'(z); b8 = 8'(b); v8 = 1'b1; end
    else begin z4 = 8'(z); b4 = 4'(b); v4 = 1'b1; end
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      #1;
      v4 = 1'b0;
      v8 = 1'b0;
      @(negedge clk);
      for (int s = 0; s < ns; s++) begin
        sample(wide, s, v, x);
        if (v) begin
          pulses[s]++;
          if (lat[s] == 0) begin lat[s] = c; got[s] = x; end
        end
      end
    end
    for (int s = 0; s < ns; s++)
      check($sformatf("%s_s%0d", name, s), pk(pulses[s] * 16 + lat[s], got[s]), pk(16 + s + 1, e));
  endtask

  // Streams the queued inputs on consecutive cycles into both widths; result k
  // of an S-stage instance must appear exactly k+S+1 cycles after the first input.
  task automatic run_stream(input string tag);
    int n4 = s4z.size();
    int n8 = s8z.size();
    int nmax = (n4 > n8) ? n4 : n8;
    int idx4[4];
    int idx8[8];
    for (int s = 0; s < 4; s++) idx4[s] = 0;
    for (int s = 0; s < 8; s++) idx8[s] = 0;
    @(negedge clk);
    fork
      begin
        for (int k = 0; k < nmax; k++) begin
          @(posedge clk);
          #1;
          v4 = (k < n4);
          v8 = (k < n8);
          if (k < n4) begin z4 = 8'(s4z[k]); b4 = 4'(s4b[k]); end
          if (k < n8) begin z8 = 16'(s8z[k]); b8 = 8'(s8b[k]); end
        end
        @(posedge clk);
        #1;
        v4 = 1'b0;
        v8 = 1'b0;
      end
      begin
        logic v;
        res_t x;
        for (int c = 0; c < nmax + 12; c++) begin
          @(negedge clk);
          for (int s = 0; s < 4; s++) begin
            sample(1'b0, s, v, x);
            if (v) begin
              if (idx4[s] < n4)
                check($sformatf("%s_n4s%0d_k%0d", tag, s, idx4[s]), pk(c, x), pk(idx4[s] + s + 1, e4[idx4[s]]));
              else
                check($sformatf("%s_n4s%0d_stray", tag, s), 32'(v), 32'h0);
              idx4[s]++;
            end
          end
          for (int s = 0; s < 8; s++) begin
            sample(1'b1, s, v, x);
            if (v) begin
              if (idx8[s] < n8)
                check($sformatf("%s_n8s%0d_k%0d", tag, s, idx8[s]), pk(c, x), pk(idx8[s] + s + 1, e8[idx8[s]]));
              else
                check($sformatf("%s_n8s%0d_stray", tag, s), 32'(v), 32'h0);
              idx8[s]++;
            end
          end
        end
      end
    join
    for (int s = 0; s < 4; s++) check($sformatf("%s_n4s%0d_count", tag, s), 32'(idx4[s]), 32'(n4));
    for (int s = 0; s < 8; s++) check($sformatf("%s_n8s%0d_count", tag, s), 32'(idx8[s]), 32'(n8));
  endtask

  task automatic clear_queues();
    s4z.delete(); s4b.delete(); e4.delete();
    s8z.delete(); s8b.delete(); e8.delete();
  endtask

  initial begin
    vec_t tbl[$];
    int   z, b;

    // Reset state, held and just after a synchronous release.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset_held");
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset_released");

    // Hand-derived vectors, including the flagged and boundary cases.
    tbl.push_back(mkvec(1'b0, 45,   7,    mkres(6, 3, 1'b0, 1'b0),      "z45_b7"));
    tbl.push_back(mkvec(1'b0, 'h70, 7,    mkres('hF, 0, 1'b0, 1'b1),    "ovf_70_7"));
    tbl.push_back(mkvec(1'b0, 'h23, 0,    mkres('hF, 0, 1'b1, 1'b0),    "dz_23_0"));
    tbl.push_back(mkvec(1'b0, 0,    5,    mkres(0, 0, 1'b0, 1'b0),      "z0"));
    tbl.push_back(mkvec(1'b0, 'h0C, 1,    mkres('hC, 0, 1'b0, 1'b0),    "b1"));
    tbl.push_back(mkvec(1'b0, 'h10, 1,    mkres('hF, 0, 1'b0, 1'b1),    "b1_ovf"));
    tbl.push_back(mkvec(1'b0, 5,    9,    mkres(0, 5, 1'b0, 1'b0),      "z_lt_b"));
    tbl.push_back(mkvec(1'b0, 'hEF, 'hF,  mkres('hF, 'hE, 1'b0, 1'b0),  "qmax"));
    tbl.push_back(mkvec(1'b0, 'hFF, 'hF,  mkres('hF, 0, 1'b0, 1'b1),    "ovf_edge"));
    tbl.push_back(mkvec(1'b1, 'h1234, 'h40, mkres('h48, 'h34, 1'b0, 1'b0), "w_1234_40"));
    tbl.push_back(mkvec(1'b1, 'hFE01, 'hFF, mkres('hFF, 0, 1'b0, 1'b0),    "w_ffsq"));
    tbl.push_back(mkvec(1'b1, 'hFF00, 'hFF, mkres('hFF, 0, 1'b0, 1'b1),    "w_ovf"));
    tbl.push_back(mkvec(1'b1, 1000,   0,    mkres('hFF, 0, 1'b1, 1'b0),    "w_dz"));
    for (int i = 0; i < tbl.size(); i++)
      op(tbl[i].wide, tbl[i].z, tbl[i].b, tbl[i].e, tbl[i].name);

    // Isolated random operations against the model.
    for (int i = 0; i < 6; i++) begin
      z = int'($urandom_range(0, 255));
      b = int'($urandom_range(0, 15));
      op(1'b0, z, b, model(4, z, b), $sformatf("rnd4_%0d", i));
      b = int'($urandom_range(0, 255));
      z = (i % 2 == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, b * 256));
      op(1'b1, z, b, model(8, z, b), $sformatf("rnd8_%0d", i));
    end

    // Back-to-back random stream, mostly non-overflowing operands.
    clear_queues();
    for (int k = 0; k < 16; k++) begin
      b = int'($urandom_range(0, 15));
      z = (k % 4 == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, b * 16));
      if (z > 255) z = 255;
      s4z.push_back(z); s4b.push_back(b); e4.push_back(model(4, z, b));
      b = int'($urandom_range(0, 255));
      z = (k % 4 == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, b * 256));
      if (z > 65535) z = 65535;
      s8z.push_back(z); s8b.push_back(b); e8.push_back(model(8, z, b));
    end
    run_stream("b2b");

    // Round trip of every product A*B with B != 0 must return Q=A, R=0.
    clear_queues();
    for (int a = 0; a < 16; a++)
      for (int bb = 1; bb < 16; bb++) begin
        s4z.push_back(a * bb); s4b.push_back(bb); e4.push_back(mkres(a, 0, 1'b0, 1'b0));
      end
    run_stream("rt");

    // Reset with three operations in flight drops them all.
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      v4 = 1'b1; z4 = 8'(20 + k); b4 = 4'd3;
      v8 = 1'b1; z8 = 16'(500 + k); b8 = 8'd7;
    end
    @(posedge clk);
    #1;
    v4 = 1'b0;
    v8 = 1'b0;
    #2 rst = 1'b1;
    #1 check_all_zero("midrst");
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    op(1'b0, 45, 7, mkres(6, 3, 1'b0, 1'b0), "after_rst4");
    op(1'b1, 'h1234, 'h40, mkres('h48, 'h34, 1'b0, 1'b0), "after_rst8");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
